// File: rtl/multicycle_control_fsm.sv
// Control unit for the multi-cycle MIPS-subset datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB and drives every datapath strobe.
// Strobes are decoded from the registered state and latched opcode/funct.
// The one exception is the beq PC write in EXEC, which follows i_isZero directly.
module multicycle_control_fsm #(
  parameter bit P_TRAP_OVF = 1'b1,
  parameter int P_CNT_W    = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [5:0]         i_opcode,
  input  logic [5:0]         i_funct,
  input  logic               i_isZero,
  input  logic               i_isOverflow,
  output logic               o_PCWrite,
  output logic               o_PCSrc,
  output logic               o_IRWrite,
  output logic               o_regDst,
  output logic               o_regWrite,
  output logic               o_ALUSrc,
  output logic [3:0]         o_ALUcontrol,
  output logic               o_memRead,
  output logic               o_memWrite,
  output logic               o_memToReg,
  output logic [2:0]         o_state,
  output logic               o_illegal,
  output logic               o_overflowTrap,
  output logic [P_CNT_W-1:0] o_instCount
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  state_t             state_q, state_d;
  logic [5:0]         op_q, fn_q;
  logic               illegal_q, ovf_q;
  logic [P_CNT_W-1:0] cnt_q;
  logic               retire, ill_set, ovf_set;
  logic               legal;
  logic [3:0]         alu_ctl;

  // Decode helpers, all taken from the opcode/funct latched in DECODE.
  logic is_rtype, is_lw, is_sw, is_beq, is_addi, imm_op, ovf_op;
  assign is_rtype = (op_q == OP_RTYPE);
  assign is_lw    = (op_q == OP_LW);
  assign is_sw    = (op_q == OP_SW);
  assign is_beq   = (op_q == OP_BEQ);
  assign is_addi  = (op_q == OP_ADDI);
  assign imm_op   = is_lw | is_sw | is_addi;
  // Only arithmetic ops can raise a signed-overflow trap; logic ops and slt cannot.
  assign ovf_op   = is_addi | (is_rtype & ((fn_q == FN_ADD) | (fn_q == FN_SUB)));

  // Legality is judged on the live instruction bits while in DECODE.
  always_comb begin
    legal = 1'b0;
    case (i_opcode)
      OP_RTYPE: legal = (i_funct == FN_ADD) | (i_funct == FN_SUB) | (i_funct == FN_AND) |
                        (i_funct == FN_OR)  | (i_funct == FN_SLT);
      OP_LW, OP_SW, OP_BEQ, OP_ADDI: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // ALU operation for the latched instruction; memory ops and addi add, beq subtracts.
  always_comb begin
    alu_ctl = ALU_ADD;
    if (is_rtype) begin
      case (fn_q)
        FN_SUB:  alu_ctl = ALU_SUB;
        FN_AND:  alu_ctl = ALU_AND;
        FN_OR:   alu_ctl = ALU_OR;
        FN_SLT:  alu_ctl = ALU_SLT;
        default: alu_ctl = ALU_ADD;
      endcase
    end else if (is_beq) begin
      alu_ctl = ALU_SUB;
    end
  end

  // Next-state logic plus retire / trap-cause events.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    ill_set = 1'b0;
    ovf_set = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (legal) state_d = S_EXEC;
        else begin
          state_d = S_TRAP;
          ill_set = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_beq) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (is_lw | is_sw) begin
          state_d = S_MEM;
        end else if (P_TRAP_OVF && i_isOverflow && ovf_op) begin
          state_d = S_TRAP;
          ovf_set = 1'b1;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (is_lw) state_d = S_WB;
        else begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP:   state_d = S_TRAP;
      // Unused codes can only come from an upset; treat them as an illegal trap.
      default: begin
        state_d = S_TRAP;
        ill_set = 1'b1;
      end
    endcase
  end

  // State, latched instruction fields, sticky trap flags and retire counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      fn_q      <= '0;
      illegal_q <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= i_opcode;
        fn_q <= i_funct;
      end
      if (ill_set) illegal_q <= 1'b1;
      if (ovf_set) ovf_q     <= 1'b1;
      if (retire)  cnt_q     <= cnt_q + P_CNT_W'(1);
    end
  end

  // Strobe decode; reset gates everything so an abort never leaves a partial strobe.
  always_comb begin
    o_PCWrite    = 1'b0;
    o_PCSrc      = 1'b0;
    o_IRWrite    = 1'b0;
    o_regDst     = 1'b0;
    o_regWrite   = 1'b0;
    o_ALUSrc     = 1'b0;
    o_ALUcontrol = 4'b0000;
    o_memRead    = 1'b0;
    o_memWrite   = 1'b0;
    o_memToReg   = 1'b0;
    if (!i_rst) begin
      case (state_q)
        S_FETCH: begin
          o_IRWrite = 1'b1;
          o_PCWrite = 1'b1;
        end
        S_EXEC: begin
          o_ALUcontrol = alu_ctl;
          o_ALUSrc     = imm_op;
          if (is_beq) begin
            o_PCSrc   = 1'b1;
            o_PCWrite = i_isZero;
          end
        end
        // ALU controls stay at their EXEC values so the address/result remains valid.
        S_MEM: begin
          o_ALUcontrol = alu_ctl;
          o_ALUSrc     = imm_op;
          o_memRead    = is_lw;
          o_memWrite   = is_sw;
        end
        S_WB: begin
          o_ALUcontrol = alu_ctl;
          o_ALUSrc     = imm_op;
          o_regWrite   = 1'b1;
          o_regDst     = is_rtype;
          o_memToReg   = is_lw;
        end
        default: ;
      endcase
    end
  end

  assign o_state        = state_q;
  assign o_illegal      = illegal_q;
  assign o_overflowTrap = ovf_q;
  assign o_instCount    = cnt_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: table of instructions with expected state
// sequences, an independent strobe reference, and hand sequences for traps/reset.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       zero, ovf;

  // dut0 traps on overflow, dut1 ignores it
  logic       d0_pcw, d0_pcs, d0_irw, d0_rdst, d0_rw, d0_asrc, d0_mr, d0_mw, d0_m2r, d0_ill, d0_ovt;
  logic [3:0] d0_aluc;
  logic [2:0] d0_st;
  logic [15:0] d0_cnt;
  logic       d1_pcw, d1_pcs, d1_irw, d1_rdst, d1_rw, d1_asrc, d1_mr, d1_mw, d1_m2r, d1_ill, d1_ovt;
  logic [3:0] d1_aluc;
  logic [2:0] d1_st;
  logic [15:0] d1_cnt;

  multicycle_control_fsm #(.P_TRAP_OVF(1'b1), .P_CNT_W(16)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_funct(funct), .i_isZero(zero),
    .i_isOverflow(ovf), .o_PCWrite(d0_pcw), .o_PCSrc(d0_pcs), .o_IRWrite(d0_irw),
    .o_regDst(d0_rdst), .o_regWrite(d0_rw), .o_ALUSrc(d0_asrc), .o_ALUcontrol(d0_aluc),
    .o_memRead(d0_mr), .o_memWrite(d0_mw), .o_memToReg(d0_m2r), .o_state(d0_st),
    .o_illegal(d0_ill), .o_overflowTrap(d0_ovt), .o_instCount(d0_cnt));

  multicycle_control_fsm #(.P_TRAP_OVF(1'b0), .P_CNT_W(16)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_funct(funct), .i_isZero(zero),
    .i_isOverflow(ovf), .o_PCWrite(d1_pcw), .o_PCSrc(d1_pcs), .o_IRWrite(d1_irw),
    .o_regDst(d1_rdst), .o_regWrite(d1_rw), .o_ALUSrc(d1_asrc), .o_ALUcontrol(d1_aluc),
    .o_memRead(d1_mr), .o_memWrite(d1_mw), .o_memToReg(d1_m2r), .o_state(d1_st),
    .o_illegal(d1_ill), .o_overflowTrap(d1_ovt), .o_instCount(d1_cnt));

  always #5 clk = ~clk;

  typedef struct packed {
    logic pcw, pcs, irw, rdst, rw, asrc;
    logic [3:0] aluc;
    logic mr, mw, m2r;
  } strb_t;

  typedef struct {
    logic [2:0]  st;
    strb_t       s;
    logic        ill, ov;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic [5:0] op, fn;
    logic       z, o;
    int         len;
    logic [2:0] seq [5];
  } vec_t;

  strb_t a0;
  assign a0 = {d0_pcw, d0_pcs, d0_irw, d0_rdst, d0_rw, d0_asrc, d0_aluc, d0_mr, d0_mw, d0_m2r};

  int          checks = 0;
  int          errors = 0;
  logic [15:0] cnt;
  exp_t        sb [$];
  vec_t        vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference strobes straight from the instruction table of the datapath.
  function automatic strb_t model(input logic [2:0] st, input logic [5:0] op, input logic [5:0] fn,
                                  input logic z);
    strb_t r;
    logic [3:0] ac;
    logic imm;
    r = '0;
    if (op == 6'h00)
      ac = (fn == 6'h22) ? 4'b0110 : (fn == 6'h24) ? 4'b0000 :
           (fn == 6'h25) ? 4'b0001 : (fn == 6'h2A) ? 4'b0111 : 4'b0010;
    else
      ac = (op == 6'h04) ? 4'b0110 : 4'b0010;
    imm = (op == 6'h23) || (op == 6'h2B) || (op == 6'h08);
    case (st)
      3'd0: begin r.pcw = 1'b1; r.irw = 1'b1; end
      3'd2: begin
        r.aluc = ac; r.asrc = imm;
        if (op == 6'h04) begin r.pcs = 1'b1; r.pcw = z; end
      end
      3'd3: begin r.aluc = ac; r.asrc = imm; r.mr = (op == 6'h23); r.mw = (op == 6'h2B); end
      3'd4: begin
        r.aluc = ac; r.asrc = imm; r.rw = 1'b1;
        r.rdst = (op == 6'h00); r.m2r = (op == 6'h23);
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic z,
                              input logic o, input int len);
    vec_t v;
    v.op = op; v.fn = fn; v.z = z; v.o = o; v.len = len;
    v.seq[0] = 3'd0; v.seq[1] = 3'd1; v.seq[2] = 3'd2;
    v.seq[3] = (len == 5 || op == 6'h2B) ? 3'd3 : 3'd4;
    v.seq[4] = 3'd4;
    return v;
  endfunction

  // Push the expectation for this cycle, then compare it at the falling edge.
  task automatic step(input logic [2:0] st, input logic ill, input logic ov);
    exp_t e;
    e.st = st; e.s = model(st, opcode, funct, zero); e.ill = ill; e.ov = ov; e.cnt = cnt;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk($sformatf("state[exp %0d]", e.st), 32'(d0_st), 32'(e.st));
    chk($sformatf("strobes[st %0d op %0h]", e.st, opcode), 32'(a0), 32'(e.s));
    chk($sformatf("flags[st %0d]", e.st), {30'd0, d0_ill, d0_ovt}, {30'd0, e.ill, e.ov});
    chk($sformatf("count[st %0d]", e.st), 32'(d0_cnt), 32'(e.cnt));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("reset_state", 32'(d0_st), 32'd0);
    chk("reset_strobes", 32'(a0), 32'd0);
    chk("reset_flags", {30'd0, d0_ill, d0_ovt}, 32'd0);
    chk("reset_count", 32'(d0_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cnt = '0;
  endtask

  initial begin
    vecs[0]  = mk(6'h00, 6'h20, 1'b0, 1'b0, 4);  // add
    vecs[1]  = mk(6'h00, 6'h22, 1'b0, 1'b0, 4);  // sub
    vecs[2]  = mk(6'h00, 6'h24, 1'b0, 1'b0, 4);  // and
    vecs[3]  = mk(6'h00, 6'h25, 1'b0, 1'b0, 4);  // or
    vecs[4]  = mk(6'h00, 6'h2A, 1'b0, 1'b0, 4);  // slt
    vecs[5]  = mk(6'h23, 6'h00, 1'b0, 1'b0, 5);  // lw
    vecs[6]  = mk(6'h2B, 6'h00, 1'b0, 1'b0, 4);  // sw
    vecs[7]  = mk(6'h04, 6'h00, 1'b1, 1'b0, 3);  // beq taken
    vecs[8]  = mk(6'h04, 6'h00, 1'b0, 1'b0, 3);  // beq not taken
    vecs[9]  = mk(6'h08, 6'h00, 1'b0, 1'b0, 4);  // addi
    vecs[10] = mk(6'h00, 6'h24, 1'b0, 1'b1, 4);  // and with overflow flag: no trap

    rst = 1'b1; opcode = '0; funct = '0; zero = 1'b0; ovf = 1'b0; cnt = '0;
    @(posedge clk); #1;
    repeat (2) begin
      @(negedge clk);
      chk("hold_reset_state", 32'(d0_st), 32'd0);
      chk("hold_reset_strobes", 32'(a0), 32'd0);
      @(posedge clk); #1;
    end
    do_reset();

    // Table of retiring instructions
    for (int i = 0; i < 11; i++) begin
      opcode = vecs[i].op; funct = vecs[i].fn; zero = vecs[i].z; ovf = vecs[i].o;
      for (int k = 0; k < vecs[i].len; k++) step(vecs[i].seq[k], 1'b0, 1'b0);
      cnt = cnt + 16'd1;
      if (i == 0) begin
        chk("add_retire_count", 32'(d0_cnt), 32'd1);
      end
    end
    chk("table_count_dut1", 32'(d1_cnt), 32'd11);

    // addi overflow: dut0 traps, dut1 writes back
    opcode = 6'h08; funct = 6'h00; zero = 1'b0; ovf = 1'b1;
    step(3'd0, 1'b0, 1'b0);
    step(3'd1, 1'b0, 1'b0);
    step(3'd2, 1'b0, 1'b0);
    chk("noovf_dut1_wb_state", 32'(d1_st), 32'd4);
    chk("noovf_dut1_wb_regwrite", 32'(d1_rw), 32'd1);
    for (int k = 0; k < 6; k++) begin
      step(3'd5, 1'b0, 1'b1);
      if (k == 0) chk("noovf_dut1_retired", 32'(d1_cnt), 32'(cnt) + 32'd1);
    end
    chk("ovf_trap_flag_dut1", 32'(d1_ovt), 32'd0);

    // Illegal opcode: TRAP with strobes idle for 10 cycles
    do_reset();
    opcode = 6'h3F; funct = 6'h00; ovf = 1'b0;
    step(3'd0, 1'b0, 1'b0);
    step(3'd1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) step(3'd5, 1'b1, 1'b0);

    // Reset pulsed in the middle of a lw EXEC cycle
    do_reset();
    opcode = 6'h23; funct = 6'h00;
    step(3'd0, 1'b0, 1'b0);
    step(3'd1, 1'b0, 1'b0);
    #2;
    chk("lw_exec_state", 32'(d0_st), 32'd2);
    chk("lw_exec_alusrc", 32'(d0_asrc), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_state", 32'(d0_st), 32'd0);
    chk("abort_strobes", 32'(a0), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(3'd0, 1'b0, 1'b0);
    step(3'd1, 1'b0, 1'b0);
    step(3'd2, 1'b0, 1'b0);
    step(3'd3, 1'b0, 1'b0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
